// File: rtl/cpu_port_pkg.sv
// Shared types and constants for the CPU port bridge: FSM state encoding,
// watchdog sizing helper and the fill values returned on unmapped/aborted reads.
package cpu_port_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Width of a counter that must reach TIMEOUT; never collapses to zero bits.
  function automatic int timeout_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  // Replicated across the data width: unmapped reads return zeros, aborts ones.
  localparam logic UNMAPPED_FILL = 1'b0;
  localparam logic ABORT_FILL    = 1'b1;

endpackage

// File: rtl/cpu_port_watchdog.sv
// Wait-cycle counter for an outstanding access; flags expiry once the count
// reaches TIMEOUT. TIMEOUT of 0 builds no counter and never expires.
module cpu_port_watchdog
  import cpu_port_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_count
      localparam int CNT_BITS = timeout_width(TIMEOUT);
      localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(TIMEOUT);

      logic [CNT_BITS-1:0] count;

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      always_ff @(posedge CLK) begin
        if (!RSTb) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (count_en && (count != LIMIT)) begin
          count <= count + 1'b1;
        end
      end

      assign expired = (count == LIMIT);
    end else begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = &{1'b0, CLK, RSTb, clear, count_en};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_port_bridge.sv
// Registers one CPU port request at a time, steers it to the channel chosen by
// the upper address bits and holds the strobe until ready or watchdog abort.
module cpu_port_bridge
  import cpu_port_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int CHANNELS     = 4,
  parameter int CH_SEL_BITS  = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic [ADDRESS_BITS-1:0]  cpu_addr_in,
  input  logic [BITS-1:0]          cpu_data_in,
  input  logic                     cpu_rd_in,
  input  logic                     cpu_wr_in,
  output logic                     cpu_stall,
  output logic [BITS-1:0]          cpu_rd_data,
  output logic                     cpu_rd_valid,
  output logic                     cpu_timeout,
  output logic [ADDRESS_BITS-1:0]  ch_address,
  output logic [BITS-1:0]          ch_data,
  output logic [CHANNELS-1:0]      ch_rd,
  output logic [CHANNELS-1:0]      ch_wr,
  input  logic [CHANNELS*BITS-1:0] ch_rd_data,
  input  logic [CHANNELS-1:0]      ch_ready
);

  localparam logic [CH_SEL_BITS:0] CH_LIMIT = (CH_SEL_BITS + 1)'(CHANNELS);

  state_t state, state_next;

  logic [CH_SEL_BITS-1:0] req_sel, sel_q;
  logic                   req_valid, req_mapped;
  logic                   is_read_q, mapped_q;
  logic [CHANNELS-1:0]    req_onehot;
  logic [BITS-1:0]        sel_rd_data;
  logic                   ready_hit, expired;
  logic                   accept, complete, abort, count_en;

  assign req_sel    = cpu_addr_in[ADDRESS_BITS-1 -: CH_SEL_BITS];
  assign req_valid  = cpu_rd_in ^ cpu_wr_in;
  assign req_mapped = ({1'b0, req_sel} < CH_LIMIT);

  // Decode for the incoming request and read-data mux for the latched channel.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_onehot  = '0;
    sel_rd_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (req_sel == CH_SEL_BITS'(k)) req_onehot[k] = 1'b1;
      if (sel_q == CH_SEL_BITS'(k))   sel_rd_data   = ch_rd_data[k*BITS +: BITS];
    end
  end

  // Live strobes equal the selected channel mask; unmapped accesses answer at once.
  assign ready_hit = !mapped_q || |(ch_ready & (ch_rd | ch_wr));

  cpu_port_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .clear    (accept),
    .count_en (count_en),
    .expired  (expired)
  );

  always_ff @(posedge CLK) begin
    if (!RSTb) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)            state_next = ACCESS;
      ACCESS:  if (ready_hit || expired) state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Ready has priority over a coincident watchdog expiry.
  always_comb begin
    accept   = (state == IDLE) && req_valid;
    complete = (state == ACCESS) && ready_hit;
    abort    = (state == ACCESS) && !ready_hit && expired;
    count_en = (state == ACCESS) && !ready_hit;
  end

  assign cpu_stall = (state == ACCESS);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      ch_address   <= '0;
      ch_data      <= '0;
      ch_rd        <= '0;
      ch_wr        <= '0;
      sel_q        <= '0;
      is_read_q    <= 1'b0;
      mapped_q     <= 1'b0;
      cpu_rd_data  <= '0;
      cpu_rd_valid <= 1'b0;
      cpu_timeout  <= 1'b0;
    end else begin
      cpu_rd_valid <= 1'b0;
      cpu_timeout  <= 1'b0;
      if (accept) begin
        ch_address <= cpu_addr_in;
        ch_data    <= cpu_data_in;
        sel_q      <= req_sel;
        is_read_q  <= cpu_rd_in;
        mapped_q   <= req_mapped;
        ch_rd      <= cpu_rd_in ? req_onehot : '0;
        ch_wr      <= cpu_wr_in ? req_onehot : '0;
      end
      if (complete || abort) begin
        ch_rd       <= '0;
        ch_wr       <= '0;
        cpu_timeout <= abort;
        if (is_read_q) begin
          cpu_rd_valid <= 1'b1;
          if (abort)         cpu_rd_data <= {BITS{ABORT_FILL}};
          else if (mapped_q) cpu_rd_data <= sel_rd_data;
          else               cpu_rd_data <= {BITS{UNMAPPED_FILL}};
        end
      end
    end
  end

endmodule
